// File: rtl/keypad_scanner.sv
// 4x4 matrix hex keypad scanner: synchronizes rows, scans columns on a slow tick,
// debounces press and release, and shifts each accepted nibble into a 16-bit register.
module keypad_scanner #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] four_hex_out
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t        state;
    logic [3:0]    row_m, row_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    col, r, det_r, col_inc;
    logic [CW-1:0] cnt;

    function automatic logic [3:0] key_map(input logic [1:0] rr, input logic [1:0] cc);
        logic [3:0] k;
        case ({rr, cc})
            4'd0:  k = 4'h1;
            4'd1:  k = 4'h2;
            4'd2:  k = 4'h3;
            4'd3:  k = 4'hA;
            4'd4:  k = 4'h4;
            4'd5:  k = 4'h5;
            4'd6:  k = 4'h6;
            4'd7:  k = 4'hB;
            4'd8:  k = 4'h7;
            4'd9:  k = 4'h8;
            4'd10: k = 4'h9;
            4'd11: k = 4'hC;
            4'd12: k = 4'hE;
            4'd13: k = 4'h0;
            4'd14: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Lowest-index low row wins when several keys share the active column.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

    assign tick    = (div_cnt == '0);
    assign det_r   = low_row(row_s);
    assign col_inc = col + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= ROW;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= DW'(SCAN_DIV - 1);
        else           div_cnt <= div_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SCAN;
            col          <= 2'd0;
            r            <= 2'd0;
            cnt          <= '0;
            COL          <= 4'b1110;
            key_valid    <= 1'b0;
            key_code     <= 4'h0;
            four_hex_out <= 16'h0000;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_s != 4'hF) begin
                            r <= det_r;
                            // The detection tick is the first agreeing sample.
                            if (DEBOUNCE_TICKS == 1) begin
                                state        <= HOLD;
                                cnt          <= '0;
                                key_valid    <= 1'b1;
                                key_code     <= key_map(det_r, col);
                                four_hex_out <= {four_hex_out[11:0], key_map(det_r, col)};
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= CW'(1);
                            end
                        end else begin
                            col <= col_inc;
                            COL <= ~(4'b0001 << col_inc);
                        end
                    end
                    DEBOUNCE: begin
                        if (!row_s[r]) begin
                            if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                                state        <= HOLD;
                                cnt          <= '0;
                                key_valid    <= 1'b1;
                                key_code     <= key_map(r, col);
                                four_hex_out <= {four_hex_out[11:0], key_map(r, col)};
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= SCAN;
                            cnt   <= '0;
                            col   <= col_inc;
                            COL   <= ~(4'b0001 << col_inc);
                        end
                    end
                    HOLD: begin
                        if (row_s[r]) begin
                            if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                                state <= SCAN;
                                cnt   <= '0;
                                col   <= col_inc;
                                COL   <= ~(4'b0001 << col_inc);
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives ROW from COL; a DEBOUNCE_TICKS=1
// instance runs alongside the main one to cover the single-sample path.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DT = 3;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ROW, ROW2, COL, COL2, key_code, code2;
    logic        key_valid, kv2;
    logic [15:0] four_hex_out, hex2;
    logic [3:0][3:0] keys;

    int          checks = 0, errors = 0, kv_cnt = 0, kv2_cnt = 0;
    logic        prev_kv = 1'b0, prev_kv2 = 1'b0;
    vec_t        tbl[16];
    int          b, b2, idx, hold, rel;
    logic        found;
    logic [15:0] model_hex;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .rst_n(rst_n), .ROW(ROW), .COL(COL),
        .key_valid(key_valid), .key_code(key_code), .four_hex_out(four_hex_out)
    );

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ROW(ROW2), .COL(COL2),
        .key_valid(kv2), .key_code(code2), .four_hex_out(hex2)
    );

    // A pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        ROW  = 4'hF;
        ROW2 = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (keys[rr][cc]) begin
                    if (!COL[cc])  ROW[rr]  = 1'b0;
                    if (!COL2[cc]) ROW2[rr] = 1'b0;
                end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            chk("kv_back_to_back", {15'b0, prev_kv}, 16'h0);
        end
        if (kv2) begin
            kv2_cnt++;
            chk("kv1_back_to_back", {15'b0, prev_kv2}, 16'h0);
        end
        prev_kv  = key_valid;
        prev_kv2 = kv2;
    end

    task automatic wait_ticks(input int n);
        repeat (n * SD) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2}; tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
        tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5}; tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
        tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8}; tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
        tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0}; tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};
        keys  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_col", {12'b0, COL}, 16'h000E);
        chk("reset_kv", {15'b0, key_valid}, 16'h0);
        chk("reset_code", {12'b0, key_code}, 16'h0);
        chk("reset_hex", four_hex_out, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Key '5' held for 100 ticks, then released.
        wait_ticks(2);
        b = kv_cnt;
        keys[1][1] = 1'b1;
        wait_ticks(100);
        chk("k5_pulses", 16'(kv_cnt - b), 16'd1);
        chk("k5_code", {12'b0, key_code}, 16'h0005);
        chk("k5_hex", four_hex_out, 16'h0005);
        chk("k5_col_hold", {12'b0, COL}, 16'h000D);
        keys = '0;
        wait_ticks(2);
        chk("k5_col_rel2", {12'b0, COL}, 16'h000D);
        wait_ticks(3);
        chk("k5_col_moved", {15'b0, COL != 4'b1101}, 16'h1);
        chk("k5_pulses_end", 16'(kv_cnt - b), 16'd1);

        // 1,2,3,A,B typed in order.
        do_reset();
        b = kv_cnt;
        for (int i = 0; i < 5; i++) begin
            idx = (i < 4) ? i : 7;
            keys[tbl[idx].r][tbl[idx].c] = 1'b1;
            wait_ticks(10);
            keys = '0;
            wait_ticks(10);
        end
        chk("seq_pulses", 16'(kv_cnt - b), 16'd5);
        chk("seq_hex", four_hex_out, 16'h23AB);

        // Key '9' seen for only two tick samples.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (COL == 4'b1011) found = 1'b1;
        end
        chk("bounce_col_seen", {15'b0, found}, 16'h1);
        b = kv_cnt;
        keys[2][2] = 1'b1;
        repeat (7) @(negedge clk);
        keys = '0;
        found = 1'b0;
        for (int k = 0; k < 3 * SD + 4 && !found; k++) begin
            @(negedge clk);
            if (COL != 4'b1011) found = 1'b1;
        end
        chk("bounce_col_next", {12'b0, COL}, 16'h0007);
        wait_ticks(4);
        chk("bounce_pulses", 16'(kv_cnt - b), 16'd0);

        // Key '0' with a chattering release.
        b = kv_cnt;
        keys[3][1] = 1'b1;
        wait_ticks(10);
        for (int i = 0; i < 6; i++) begin
            keys[3][1] = ~keys[3][1];
            wait_ticks(1);
        end
        keys = '0;
        wait_ticks(8);
        chk("relbounce_pulses", 16'(kv_cnt - b), 16'd1);
        chk("relbounce_code", {12'b0, key_code}, 16'h0000);

        // Rows 1 and 3 low in column 0, then reset during the hold.
        b = kv_cnt;
        keys[1][0] = 1'b1;
        keys[3][0] = 1'b1;
        wait_ticks(8);
        chk("multi_pulses", 16'(kv_cnt - b), 16'd1);
        chk("multi_code", {12'b0, key_code}, 16'h0004);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_col", {12'b0, COL}, 16'h000E);
        chk("midrst_kv", {15'b0, key_valid}, 16'h0);
        chk("midrst_code", {12'b0, key_code}, 16'h0);
        chk("midrst_hex", four_hex_out, 16'h0000);
        repeat (2) @(negedge clk);
        b = kv_cnt;
        rst_n = 1'b1;
        wait_ticks(8);
        chk("postrst_pulses", 16'(kv_cnt - b), 16'd1);
        chk("postrst_code", {12'b0, key_code}, 16'h0004);
        keys = '0;
        wait_ticks(8);

        // Full key map, both debounce depths.
        do_reset();
        model_hex = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            b  = kv_cnt;
            b2 = kv2_cnt;
            keys[tbl[i].r][tbl[i].c] = 1'b1;
            wait_ticks(10);
            keys = '0;
            wait_ticks(8);
            model_hex = {model_hex[11:0], tbl[i].code};
            chk("tbl_pulses", 16'(kv_cnt - b), 16'd1);
            chk("tbl_code", {12'b0, key_code}, {12'b0, tbl[i].code});
            chk("tbl_hex", four_hex_out, model_hex);
            chk("tbl1_pulses", 16'(kv2_cnt - b2), 16'd1);
            chk("tbl1_code", {12'b0, code2}, {12'b0, tbl[i].code});
        end

        // Random keys with random hold and gap lengths.
        for (int i = 0; i < 20; i++) begin
            idx  = $urandom_range(15, 0);
            hold = $urandom_range(16, 10);
            rel  = $urandom_range(12, 6);
            b  = kv_cnt;
            b2 = kv2_cnt;
            keys[tbl[idx].r][tbl[idx].c] = 1'b1;
            wait_ticks(hold);
            keys = '0;
            wait_ticks(rel);
            model_hex = {model_hex[11:0], tbl[idx].code};
            chk("rnd_pulses", 16'(kv_cnt - b), 16'd1);
            chk("rnd_hex", four_hex_out, model_hex);
            chk("rnd1_pulses", 16'(kv2_cnt - b2), 16'd1);
            chk("rnd1_hex", hex2, model_hex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
